shifter_arbiter: RTL and testbench

//  Shares one ShifterSignExtender (operand-2 / offset shifter) between two requesters:
//  req0 = ALU operand-2 path, req1 = load/store address-offset path.

---
 rtl/shifter_arbiter.sv | 148 ++++++++++++++
 tb/tb_shifter_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shifter_arbiter.sv
// Round-robin share of one operand/offset shifter between the ALU (req0) and load/store (req1) paths.
// Define SHARB_STATS_EN to add saturating per-requester grant counters (grant_cnt0/1).
module shifter_arbiter #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_rm,
  input  logic [11:0]      req0_i,
  input  logic [1:0]       req0_am,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_rm,
  input  logic [11:0]      req1_i,
  input  logic [1:0]       req1_am,
  input  logic [TAG_W-1:0] req1_tag,
  output logic [31:0]      sh_rm,
  output logic [11:0]      sh_i,
  output logic [1:0]       sh_am,
  input  logic [31:0]      sh_n,
`ifdef SHARB_STATS_EN
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1,
`endif
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [31:0]      rsp_n
);

  // state | meaning
  // EMPTY | response slot free, any request may be granted
  // FULL  | response slot holds a result until rsp_ready
  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state_q, state_d;
  logic             prio_q, prio_d;
  logic             rsp_id_q, rsp_id_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic [31:0]      rsp_n_q, rsp_n_d;

  logic can_accept;
  logic grant;
  logic grant_id;

  always_comb begin
    can_accept = (state_q == EMPTY) | rsp_ready;
    grant      = 1'b0;
    grant_id   = 1'b0;
    if (can_accept) begin
      if (req0_valid & req1_valid) begin
        grant    = 1'b1;
        grant_id = prio_q;
      end else if (req0_valid) begin
        grant    = 1'b1;
      end else if (req1_valid) begin
        grant    = 1'b1;
        grant_id = 1'b1;
      end
    end
  end

  always_comb begin
    req0_ready = grant & ~grant_id;
    req1_ready = grant & grant_id;
    sh_rm      = '0;
    sh_i       = '0;
    sh_am      = '0;
    if (grant) begin
      sh_rm = grant_id ? req1_rm : req0_rm;
      sh_i  = grant_id ? req1_i  : req0_i;
      sh_am = grant_id ? req1_am : req0_am;
    end
  end

  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    rsp_id_d  = rsp_id_q;
    rsp_tag_d = rsp_tag_q;
    rsp_n_d   = rsp_n_q;
    // A grant in FULL retires the old result and loads the new one on the same edge.
    if (grant) begin
      state_d   = FULL;
      prio_d    = ~grant_id;
      rsp_id_d  = grant_id;
      rsp_tag_d = grant_id ? req1_tag : req0_tag;
      rsp_n_d   = sh_n;
    end else if ((state_q == FULL) && rsp_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= EMPTY;
      prio_q    <= 1'b0;
      rsp_id_q  <= 1'b0;
      rsp_tag_q <= '0;
      rsp_n_q   <= '0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      rsp_id_q  <= rsp_id_d;
      rsp_tag_q <= rsp_tag_d;
      rsp_n_q   <= rsp_n_d;
    end
  end

  assign rsp_valid = (state_q == FULL);
  assign rsp_id    = rsp_id_q;
  assign rsp_tag   = rsp_tag_q;
  assign rsp_n     = rsp_n_q;

`ifdef SHARB_STATS_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (grant & ~grant_id & (cnt0_q != '1)) cnt0_d = cnt0_q + CNT_W'(1);
    if (grant & grant_id & (cnt1_q != '1))  cnt1_d = cnt1_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`else
  logic [CNT_W-1:0] cnt_unused;
  assign cnt_unused = '0;
`endif

endmodule

// File: tb/tb_shifter_arbiter.sv
// Bench for shifter_arbiter: directed vector table, hand-written corner sequences and a random
// run against a transaction-level model. The shared shifter is modelled here as a function.
module tb_shifter_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_rm, req1_rm;
  logic [11:0] req0_i, req1_i;
  logic [1:0]  req0_am, req1_am;
  logic [3:0]  req0_tag, req1_tag;
  logic [31:0] sh_rm, sh_n;
  logic [11:0] sh_i;
  logic [1:0]  sh_am;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [3:0]  rsp_tag;
  logic [31:0] rsp_n;
`ifdef SHARB_STATS_EN
  logic [1:0]  grant_cnt0, grant_cnt1;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  shifter_arbiter #(.TAG_W(4), .CNT_W(2)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rm(req0_rm), .req0_i(req0_i),
    .req0_am(req0_am), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rm(req1_rm), .req1_i(req1_i),
    .req1_am(req1_am), .req1_tag(req1_tag),
    .sh_rm(sh_rm), .sh_i(sh_i), .sh_am(sh_am), .sh_n(sh_n),
`ifdef SHARB_STATS_EN
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1),
`endif
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_tag(rsp_tag), .rsp_n(rsp_n)
  );

  // Shifter stand-in: 00 rotated imm8, 01 Rm, 10 zero-extended imm12, 11 Rm shifted by i[11:7]/type i[6:5].
  function automatic logic [31:0] shift_ref(logic [31:0] rm, logic [11:0] i, logic [1:0] am);
    logic [63:0] w;
    logic [31:0] r;
    int sh;
    r = 32'h0;
    case (am)
      2'd0: begin
        sh = 2 * int'(i[11:8]);
        w  = {24'h0, i[7:0], 24'h0, i[7:0]} >> sh;
        r  = w[31:0];
      end
      2'd1: r = rm;
      2'd2: r = {20'h0, i};
      default: begin
        sh = int'(i[11:7]);
        case (i[6:5])
          2'd0: r = rm << sh;
          2'd1: r = rm >> sh;
          2'd2: r = $signed(rm) >>> sh;
          default: begin
            w = {rm, rm} >> sh;
            r = w[31:0];
          end
        endcase
      end
    endcase
    return r;
  endfunction

  assign sh_n = shift_ref(sh_rm, sh_i, sh_am);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: slot contents, favoured side, grant counts.
  logic        m_valid, m_id, m_fav;
  logic [3:0]  m_tag;
  logic [31:0] m_n;
  logic [1:0]  m_cnt0, m_cnt1;
  logic        e_g, e_gid;
  logic [3:0]  e_tag;
  logic [31:0] e_n;

  task automatic model_reset();
    m_valid = 1'b0; m_id = 1'b0; m_fav = 1'b0; m_tag = 4'h0; m_n = 32'h0;
    m_cnt0 = 2'd0; m_cnt1 = 2'd0;
  endtask

  task automatic pre_edge();
    logic        acc;
    logic [31:0] xrm;
    logic [11:0] xi;
    logic [1:0]  xam;
    #1;
    acc   = !m_valid || rsp_ready;
    e_g   = acc && (req0_valid || req1_valid);
    e_gid = (req0_valid && req1_valid) ? m_fav : !req0_valid;
    xrm = 32'h0; xi = 12'h0; xam = 2'h0; e_tag = 4'h0; e_n = 32'h0;
    if (e_g) begin
      xrm   = e_gid ? req1_rm  : req0_rm;
      xi    = e_gid ? req1_i   : req0_i;
      xam   = e_gid ? req1_am  : req0_am;
      e_tag = e_gid ? req1_tag : req0_tag;
      e_n   = shift_ref(xrm, xi, xam);
    end
    chk("req0_ready", 32'(req0_ready), 32'(e_g && !e_gid));
    chk("req1_ready", 32'(req1_ready), 32'(e_g && e_gid));
    chk("sh_rm", sh_rm, xrm);
    chk("sh_i", 32'(sh_i), 32'(xi));
    chk("sh_am", 32'(sh_am), 32'(xam));
  endtask

  task automatic post_edge();
    logic rdy_at_edge;
    rdy_at_edge = rsp_ready;
    @(posedge clk);
    #1;
    if (e_g) begin
      m_valid = 1'b1; m_id = e_gid; m_tag = e_tag; m_n = e_n; m_fav = !e_gid;
      if (!e_gid && m_cnt0 != 2'd3) m_cnt0++;
      if (e_gid && m_cnt1 != 2'd3) m_cnt1++;
    end else if (rdy_at_edge) begin
      m_valid = 1'b0;
    end
    chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    if (m_valid) begin
      chk("rsp_id", 32'(rsp_id), 32'(m_id));
      chk("rsp_tag", 32'(rsp_tag), 32'(m_tag));
      chk("rsp_n", rsp_n, m_n);
    end
`ifdef SHARB_STATS_EN
    chk("grant_cnt0", 32'(grant_cnt0), 32'(m_cnt0));
    chk("grant_cnt1", 32'(grant_cnt1), 32'(m_cnt1));
`endif
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req0_rm = 0; req0_i = 0; req0_am = 0; req0_tag = 0;
    req1_valid = 0; req1_rm = 0; req1_i = 0; req1_am = 0; req1_tag = 0;
    rsp_ready = 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    model_reset();
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_id", 32'(rsp_id), 32'h0);
    chk("rst_rsp_tag", 32'(rsp_tag), 32'h0);
    chk("rst_rsp_n", rsp_n, 32'h0);
`ifdef SHARB_STATS_EN
    chk("rst_grant_cnt0", 32'(grant_cnt0), 32'h0);
    chk("rst_grant_cnt1", 32'(grant_cnt1), 32'h0);
`endif
  endtask

  typedef struct {
    bit          rst;
    bit          v0, v1, rdy;
    logic [31:0] rm0; logic [11:0] i0; logic [1:0] am0; logic [3:0] tg0;
    logic [31:0] rm1; logic [11:0] i1; logic [1:0] am1; logic [3:0] tg1;
    bit          er0, er1, ev, eid;
    logic [3:0]  etag;
    logic [31:0] en;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int n0, n1;
    logic [31:0] held_n;
    logic [3:0]  held_tag;
    logic        held_id;

    vecs[0] = '{1,1,0,1, 32'h0,12'h4FF,2'd0,4'h3, 32'h0,12'h0,2'd0,4'h0, 1,0,1,0,4'h3,32'hFF000000};
    vecs[1] = '{1,1,1,1, 32'h80000000,12'h240,2'd3,4'h5, 32'h1234,12'h0,2'd1,4'h9, 1,0,1,0,4'h5,32'hF8000000};
    vecs[2] = '{0,0,1,1, 32'h0,12'h0,2'd0,4'h0, 32'h1234,12'h0,2'd1,4'h9, 0,1,1,1,4'h9,32'h00001234};
    vecs[3] = '{0,0,0,1, 32'h0,12'h0,2'd0,4'h0, 32'h0,12'h0,2'd0,4'h0, 0,0,0,0,4'h0,32'h0};
    vecs[4] = '{0,1,0,0, 32'hDEADBEEF,12'hABC,2'd2,4'h7, 32'h0,12'h0,2'd0,4'h0, 1,0,1,0,4'h7,32'h00000ABC};
    vecs[5] = '{0,0,1,0, 32'h0,12'h0,2'd0,4'h0, 32'h1234,12'h200,2'd3,4'hA, 0,0,1,0,4'h7,32'h00000ABC};
    vecs[6] = '{0,0,1,1, 32'h0,12'h0,2'd0,4'h0, 32'h1234,12'h200,2'd3,4'hA, 0,1,1,1,4'hA,32'h00012340};

    reset = 1'b1;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    for (int k = 0; k < 7; k++) begin
      if (vecs[k].rst) do_reset();
      @(negedge clk);
      req0_valid = vecs[k].v0; req0_rm = vecs[k].rm0; req0_i = vecs[k].i0;
      req0_am = vecs[k].am0; req0_tag = vecs[k].tg0;
      req1_valid = vecs[k].v1; req1_rm = vecs[k].rm1; req1_i = vecs[k].i1;
      req1_am = vecs[k].am1; req1_tag = vecs[k].tg1;
      rsp_ready = vecs[k].rdy;
      pre_edge();
      chk($sformatf("vec%0d_req0_ready", k), 32'(req0_ready), 32'(vecs[k].er0));
      chk($sformatf("vec%0d_req1_ready", k), 32'(req1_ready), 32'(vecs[k].er1));
      post_edge();
      chk($sformatf("vec%0d_rsp_valid", k), 32'(rsp_valid), 32'(vecs[k].ev));
      if (vecs[k].ev) begin
        chk($sformatf("vec%0d_rsp_id", k), 32'(rsp_id), 32'(vecs[k].eid));
        chk($sformatf("vec%0d_rsp_tag", k), 32'(rsp_tag), 32'(vecs[k].etag));
        chk($sformatf("vec%0d_rsp_n", k), rsp_n, vecs[k].en);
      end
    end

    // Both held valid for 8 cycles: strict alternation starting with req0.
    do_reset();
    n0 = 0; n1 = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      req0_valid = 1; req0_rm = $urandom; req0_i = 12'($urandom); req0_am = 2'($urandom); req0_tag = 4'(k);
      req1_valid = 1; req1_rm = $urandom; req1_i = 12'($urandom); req1_am = 2'($urandom); req1_tag = 4'(k + 8);
      rsp_ready = 1;
      pre_edge();
      chk("alt_req0_ready", 32'(req0_ready), 32'(k % 2 == 0));
      if (req0_ready) n0++;
      if (req1_ready) n1++;
      post_edge();
    end
    chk("alt_grants0", 32'(n0), 32'd4);
    chk("alt_grants1", 32'(n1), 32'd4);

    // Backpressure: slot held for 5 cycles, then release grants in that same cycle.
    do_reset();
    @(negedge clk);
    req0_valid = 1; req0_rm = 32'h0000_00F0; req0_i = 12'h081; req0_am = 2'd3; req0_tag = 4'h6;
    rsp_ready = 1;
    pre_edge();
    post_edge();
    held_n = rsp_n; held_tag = rsp_tag; held_id = rsp_id;
    chk("stall_first_n", held_n, 32'h0000_01E0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      req0_valid = 1; req0_rm = 32'h1111_0000; req0_i = 12'h0; req0_am = 2'd1; req0_tag = 4'h1;
      req1_valid = 1; req1_rm = 32'h2222_0000; req1_i = 12'h0; req1_am = 2'd1; req1_tag = 4'h2;
      rsp_ready = 0;
      pre_edge();
      chk("stall_ready", 32'({req0_ready, req1_ready}), 32'h0);
      post_edge();
      chk("stall_n_stable", rsp_n, held_n);
      chk("stall_tag_stable", 32'(rsp_tag), 32'(held_tag));
      chk("stall_id_stable", 32'(rsp_id), 32'(held_id));
    end
    @(negedge clk);
    rsp_ready = 1;
    pre_edge();
    chk("stall_release_req1_ready", 32'(req1_ready), 32'h1);
    post_edge();
    chk("stall_release_n", rsp_n, 32'h2222_0000);

    // Asynchronous reset while a response is pending; priority returns to req0.
    do_reset();
    @(negedge clk);
    req0_valid = 1; req0_rm = 32'h5; req0_i = 12'h0; req0_am = 2'd1; req0_tag = 4'h4;
    rsp_ready = 0;
    pre_edge();
    post_edge();
    @(negedge clk);
    idle_inputs();
    rsp_ready = 0;
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    req0_valid = 1; req0_rm = 32'hA; req0_am = 2'd1; req0_tag = 4'h1;
    req1_valid = 1; req1_rm = 32'hB; req1_am = 2'd1; req1_tag = 4'h2;
    rsp_ready = 1;
    pre_edge();
    chk("post_rst_req0_first", 32'(req0_ready), 32'h1);
    post_edge();

`ifdef SHARB_STATS_EN
    do_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      req1_valid = 1; req1_rm = 32'(k); req1_am = 2'd1; req1_tag = 4'(k);
      rsp_ready = 1;
      pre_edge();
      post_edge();
    end
    chk("sat_grant_cnt1", 32'(grant_cnt1), 32'd3);
    chk("sat_grant_cnt0", 32'(grant_cnt0), 32'd0);
`endif

    // Random traffic against the model; requesters hold until accepted.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (!req0_valid || (e_g && !e_gid)) begin
        req0_valid = ($urandom_range(0, 2) != 0);
        req0_rm = $urandom; req0_i = 12'($urandom); req0_am = 2'($urandom); req0_tag = 4'($urandom);
      end
      if (!req1_valid || (e_g && e_gid)) begin
        req1_valid = ($urandom_range(0, 2) != 0);
        req1_rm = $urandom; req1_i = 12'($urandom); req1_am = 2'($urandom); req1_tag = 4'($urandom);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      pre_edge();
      post_edge();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
